// File: rtl/psg_wave_fetch_sched.sv
// psg_wave_fetch_sched -- round-robin sample-fetch scheduler for the PSG
// wave-table channels. One single-beat read at a time is run on the shared
// system bus. The returned data lands in the granted channel's sample
// register. A stuck transfer is aborted after TMO cycles and a sticky error
// is flagged for that channel.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   ce               clock enable; gates new grants only
//   fetch_req[NCH]   per-channel "need next sample" (pulse or level)
//   fetch_adr        per-channel sample address, ch i at [i*AW +: AW]
//   err_clr          clears all sticky timeout flags
//   cyc_o/stb_o      bus cycle / strobe (identical)
//   adr_o            bus address, latched at grant
//   ack_i, dat_i     bus completion and read data
//   sample_o         per-channel latched sample, ch i at [i*DW +: DW]
//   sample_vld[NCH]  one-cycle pulse when sample_o[i] was updated
//   cur_ch           channel owning / last owning the bus
//   busy             scheduler not idle
//   tmo_err[NCH]     sticky per-channel timeout flags

// Per-channel state: pending flag, sample register, sticky timeout flag.
module psg_wave_fetch_lane #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          done_ack,
  input  logic          done_tmo,
  input  logic          err_clr,
  input  logic [DW-1:0] dat,
  output logic          pend,
  output logic [DW-1:0] sample,
  output logic          tmo_err
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= 1'b0;
      sample  <= '0;
      tmo_err <= 1'b0;
    end else begin
      // A new request on the completing edge re-arms the channel.
      pend    <= req | (pend & ~(done_ack | done_tmo));
      if (done_ack) sample <= dat;
      tmo_err <= done_tmo | (tmo_err & ~err_clr);
    end
  end
endmodule

module psg_wave_fetch_sched #(
  parameter int NCH = 8,
  parameter int AW  = 24,
  parameter int DW  = 16,
  parameter int TMO = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic [NCH-1:0]    fetch_req,
  input  logic [NCH*AW-1:0] fetch_adr,
  input  logic              err_clr,
  output logic              cyc_o,
  output logic              stb_o,
  output logic [AW-1:0]     adr_o,
  input  logic              ack_i,
  input  logic [DW-1:0]     dat_i,
  output logic [NCH*DW-1:0] sample_o,
  output logic [NCH-1:0]    sample_vld,
  output logic [2:0]        cur_ch,
  output logic              busy,
  output logic [NCH-1:0]    tmo_err
);
  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TMO - 1);

  state_t         state, state_nxt;
  logic [NCH-1:0] pend;
  logic [2:0]     last;
  logic [2:0]     sel;
  logic           found;
  logic [7:0]     cnt;
  logic           by_ack;   // current transfer ended with ack (not timeout)
  logic           grant, hit_ack, hit_tmo;
  logic [NCH-1:0] lane_ack, lane_tmo;

  // Round-robin pick: first pending channel after the last grant.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 1; k <= NCH; k++) begin
      if (!found && pend[(int'(last) + k) % NCH]) begin
        found = 1'b1;
        sel   = 3'((int'(last) + k) % NCH);
      end
    end
  end

  assign grant   = (state == IDLE) && ce && found;
  assign hit_ack = (state == BUS) && ack_i;
  assign hit_tmo = (state == BUS) && !ack_i && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = BUS;
      BUS:     if (hit_ack || hit_tmo) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adr_o  <= '0;
      cur_ch <= '0;
      last   <= 3'(NCH - 1);
      cnt    <= '0;
      by_ack <= 1'b0;
    end else begin
      if (grant) begin
        adr_o  <= fetch_adr[int'(sel)*AW +: AW];
        cur_ch <= sel;
        last   <= sel;
        cnt    <= '0;
        by_ack <= 1'b0;
      end else if (state == BUS) begin
        by_ack <= ack_i;
        if (!ack_i) cnt <= cnt + 8'd1;
      end
    end
  end

  // Bus outputs come straight from the state so reset drops them at once.
  assign cyc_o = (state == BUS);
  assign stb_o = cyc_o;
  assign busy  = (state != IDLE);

  always_comb begin
    lane_ack   = '0;
    lane_tmo   = '0;
    sample_vld = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cur_ch == 3'(i)) begin
        lane_ack[i]   = hit_ack;
        lane_tmo[i]   = hit_tmo;
        sample_vld[i] = (state == DONE) && by_ack;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    psg_wave_fetch_lane #(.DW(DW)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (fetch_req[g]),
      .done_ack (lane_ack[g]),
      .done_tmo (lane_tmo[g]),
      .err_clr  (err_clr),
      .dat      (dat_i),
      .pend     (pend[g]),
      .sample   (sample_o[g*DW +: DW]),
      .tmo_err  (tmo_err[g])
    );
  end
endmodule
